// File: rtl/tmr_pkg.sv
// Shared constants and helpers for the timer prescaler: counter width
// derivation and the select-to-mask conversion used by each channel.
package tmr_pkg;

    localparam int CKS_W_DEF = 2;

    function automatic int cnt_w(input int cks_w);
        return 2 ** cks_w;
    endfunction

    // Low k+1 bits set; a channel's period ends when these bits of cnt are all ones.
    function automatic logic [63:0] cks2mask(input int k);
        return (64'd1 << (k + 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/tmr_prescaler_if.sv
// Control and pulse bundle between the APB-side register block and the
// prescaler; master drives run/clear/selects, slave returns enables.
interface tmr_prescaler_if #(
    parameter int NUM_CH = 4,
    parameter int CKS_W  = tmr_pkg::CKS_W_DEF
);
    logic                      presc_en;
    logic                      presc_clr;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH*CKS_W-1:0]   cks;
    logic [NUM_CH-1:0]         clk_ena;
    logic [NUM_CH*CKS_W-1:0]   cks_act;

    modport master (
        output presc_en, presc_clr, ch_en, cks,
        input  clk_ena, cks_act
    );

    modport slave (
        input  presc_en, presc_clr, ch_en, cks,
        output clk_ena, cks_act
    );
endinterface

// File: rtl/tmr_presc_ch.sv
// One prescaler channel: shadowed divide select, boundary compare against
// the shared counter, and the registered count-enable pulse.
module tmr_presc_ch
    import tmr_pkg::*;
#(
    parameter int CKS_W = CKS_W_DEF,
    parameter int CNT_W = cnt_w(CKS_W)
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              presc_en,
    input  logic              presc_clr,
    input  logic              ch_en,
    input  logic [CKS_W-1:0]  cks,
    output logic              clk_ena,
    output logic [CKS_W-1:0]  cks_act
);

    logic [CNT_W-1:0] mask;
    logic             bnd;

    always_comb begin
        mask = CNT_W'(cks2mask(int'(cks_act)));
        bnd  = presc_en & ~presc_clr & ((cnt & mask) == mask);
    end

    // The select only changes at a period boundary (or while idle/cleared),
    // so a switch can never shorten or merge a period.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            clk_ena <= 1'b0;
            cks_act <= '0;
        end else begin
            clk_ena <= bnd & ch_en;
            if (bnd | ~ch_en | presc_clr) begin
                cks_act <= cks;
            end
        end
    end

endmodule

// File: rtl/tmr_prescaler.sv
// Multi-channel timer prescaler: one shared free-running counter feeding
// NUM_CH channels that each emit a one-pclk enable at pclk/2^(cks+1).
module tmr_prescaler
    import tmr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CKS_W  = CKS_W_DEF
) (
    input  logic             pclk,
    input  logic             preset_n,
    tmr_prescaler_if.slave   bus
);

    localparam int CNT_W = cnt_w(CKS_W);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt <= '0;
        end else if (bus.presc_clr) begin
            cnt <= '0;
        end else if (bus.presc_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tmr_presc_ch #(
            .CKS_W (CKS_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .pclk      (pclk),
            .preset_n  (preset_n),
            .cnt       (cnt),
            .presc_en  (bus.presc_en),
            .presc_clr (bus.presc_clr),
            .ch_en     (bus.ch_en[i]),
            .cks       (bus.cks[i*CKS_W +: CKS_W]),
            .clk_ena   (bus.clk_ena[i]),
            .cks_act   (bus.cks_act[i*CKS_W +: CKS_W])
        );
    end

endmodule

// File: tb/tb_tmr_prescaler.sv
// Directed bench for tmr_prescaler (4 channels, CKS_W=2): start-up cadence,
// select switching, run/clear/enable control and mid-period reset.
module tb_tmr_prescaler;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tmr_prescaler_if #(.NUM_CH(4), .CKS_W(2)) bus ();

    tmr_prescaler #(.NUM_CH(4), .CKS_W(2)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Clear edge loads the shadows (ch0 div 2, ch3 div 16), then 32 running edges.
    task automatic startup(input string tag);
        bus.ch_en     = 4'b1001;
        bus.cks       = 8'b11_00_00_00;
        bus.presc_en  = 1'b1;
        bus.presc_clr = 1'b1;
        step();
        chk({tag, "_clr_cnt"}, 32'(dut.cnt), 32'd0);
        chk({tag, "_clr_act"}, 32'(bus.cks_act), 32'hC0);
        chk({tag, "_clr_ena"}, 32'(bus.clk_ena), 32'd0);
        bus.presc_clr = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            step();
            chk({tag, "_cnt"}, 32'(dut.cnt), 32'(n % 16));
            chk({tag, "_ch0"}, 32'(bus.clk_ena[0]), 32'(n % 2 == 0));
            chk({tag, "_ch3"}, 32'(bus.clk_ena[3]), 32'(n % 16 == 0));
            chk({tag, "_ch12"}, 32'(bus.clk_ena[2:1]), 32'd0);
        end
    endtask

    initial begin
        bus.presc_en  = 1'b0;
        bus.presc_clr = 1'b0;
        bus.ch_en     = '0;
        bus.cks       = '0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_ena", 32'(bus.clk_ena), 32'd0);
        chk("rst_act", 32'(bus.cks_act), 32'd0);
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
        preset_n = 1'b1;

        startup("s1");

        // Select change on a running channel waits for the old boundary.
        bus.cks[3:2] = 2'd3;
        step();
        chk("s2_cnt1", 32'(dut.cnt), 32'd1);
        chk("s2_load", 32'(bus.cks_act[3:2]), 32'd3);
        bus.ch_en[1] = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("s2_pre_ena", 32'(bus.clk_ena[1]), 32'd0);
        end
        bus.cks[3:2] = 2'd0;
        for (int c = 6; c <= 15; c++) begin
            step();
            chk("s2_old_ena", 32'(bus.clk_ena[1]), 32'd0);
            chk("s2_old_act", 32'(bus.cks_act[3:2]), 32'd3);
        end
        step();
        chk("s2_wrap_cnt", 32'(dut.cnt), 32'd0);
        chk("s2_wrap_ena", 32'(bus.clk_ena[1]), 32'd1);
        chk("s2_wrap_act", 32'(bus.cks_act[3:2]), 32'd0);
        step();
        chk("s2_new_gap", 32'(bus.clk_ena[1]), 32'd0);
        step();
        chk("s2_new_ena", 32'(bus.clk_ena[1]), 32'd1);
        chk("s2_new_cnt", 32'(dut.cnt), 32'd2);

        // presc_en low freezes the counter mid-period.
        bus.cks[5:4] = 2'd2;
        step();
        chk("s3_cnt3", 32'(dut.cnt), 32'd3);
        chk("s3_act2", 32'(bus.cks_act[5:4]), 32'd2);
        bus.ch_en[2] = 1'b1;
        step();
        chk("s3_cnt4", 32'(dut.cnt), 32'd4);
        chk("s3_ena4", 32'(bus.clk_ena[2]), 32'd0);
        bus.presc_en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("s3_hold_cnt", 32'(dut.cnt), 32'd4);
            chk("s3_hold_ena", 32'(bus.clk_ena), 32'd0);
        end
        bus.presc_en = 1'b1;
        for (int c = 5; c <= 7; c++) begin
            step();
            chk("s3_run_ena", 32'(bus.clk_ena[2]), 32'd0);
        end
        step();
        chk("s3_pulse_cnt", 32'(dut.cnt), 32'd8);
        chk("s3_pulse_ena", 32'(bus.clk_ena[2]), 32'd1);

        // Clear together with presc_en at cnt=9.
        bus.cks[1:0] = 2'd1;
        step();
        chk("s4_cnt9", 32'(dut.cnt), 32'd9);
        chk("s4_act_hold", 32'(bus.cks_act[1:0]), 32'd0);
        bus.presc_clr = 1'b1;
        step();
        chk("s4_clr_cnt", 32'(dut.cnt), 32'd0);
        chk("s4_clr_ena", 32'(bus.clk_ena), 32'd0);
        chk("s4_clr_act", 32'(bus.cks_act[1:0]), 32'd1);
        bus.presc_clr = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("s4_gap", 32'(bus.clk_ena[0]), 32'd0);
        end
        step();
        chk("s4_pulse_ena", 32'(bus.clk_ena[0]), 32'd1);
        chk("s4_pulse_cnt", 32'(dut.cnt), 32'd4);

        // Channel disable at a boundary, select written while disabled, re-enable.
        repeat (3) step();
        chk("s5_cnt7", 32'(dut.cnt), 32'd7);
        bus.ch_en[2] = 1'b0;
        step();
        chk("s5_forced", 32'(bus.clk_ena[2]), 32'd0);
        chk("s5_cnt8", 32'(dut.cnt), 32'd8);
        bus.cks[5:4] = 2'd3;
        step();
        chk("s5_act3", 32'(bus.cks_act[5:4]), 32'd3);
        chk("s5_off_ena", 32'(bus.clk_ena[2]), 32'd0);
        bus.cks[5:4] = 2'd2;
        step();
        chk("s5_act2", 32'(bus.cks_act[5:4]), 32'd2);
        chk("s5_cnt10", 32'(dut.cnt), 32'd10);
        bus.ch_en[2] = 1'b1;
        for (int c = 11; c <= 15; c++) begin
            step();
            chk("s5_wait", 32'(bus.clk_ena[2]), 32'd0);
        end
        step();
        chk("s5_first_cnt", 32'(dut.cnt), 32'd0);
        chk("s5_first_ena", 32'(bus.clk_ena[2]), 32'd1);

        // Asynchronous reset mid-period at cnt=11.
        repeat (11) step();
        chk("s6_cnt11", 32'(dut.cnt), 32'd11);
        preset_n = 1'b0;
        #2;
        chk("s6_rst_ena", 32'(bus.clk_ena), 32'd0);
        chk("s6_rst_act", 32'(bus.cks_act), 32'd0);
        chk("s6_rst_cnt", 32'(dut.cnt), 32'd0);
        step();
        preset_n = 1'b1;
        startup("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
